data_bus_initiator: RTL and testbench
=====================================

// Module: data_bus_initiator
// PURPOSE
//  Single-outstanding initiator (master end) of the Ibex data bus used by the SoC peripherals.
//  Converts a valid/ready command stream into bus transactions, then returns read data or status
//  on a valid/ready response stream. Intended for test/boot sequencers or a debug bridge to reach
//  memory-mapped peripherals (GPIO etc.). Bounded-wait timeouts; never hangs on an unmapped offset.
// PARAMETERS
//  GNT_TIMEOUT     16  max cycles req held without gnt before abort (>=1)
//  RVALID_TIMEOUT  16  max cycles waited for rvalid after gnt before abort (>=1)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous reset, active-low
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   command accepted when cmd_valid & cmd_ready
//  cmd_we         in   1   1=write, 0=read
//  cmd_addr       in   32  byte address; bits [1:0] ignored
//  cmd_be         in   4   byte enables
//  cmd_wdata      in   32  write data
//  rsp_valid      out  1   response present
//  rsp_ready      in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata      out  32  read data (0 for writes and aborted transactions)
//  rsp_err        out  1   slave returned err with rvalid
//  rsp_timeout    out  1   transaction aborted by gnt or rvalid timeout
//  bus_req        out  1   bus request
//  bus_gnt        in   1   bus grant (slave may drive combinationally from req/addr)
//  bus_we         out  1   write enable
//  bus_be         out  4   byte enables
//  bus_addr       out  32  {cmd_addr[31:2],2'b00}
//  bus_wdata      out  32  write data
//  bus_wdata_intg out  7   tied 0
//  bus_rvalid     in   1   response valid
//  bus_rdata      in   32  read data
//  bus_err        in   1   response error
// BEHAVIOUR
//  - Reset values: state IDLE; cmd_ready=1; rsp_valid, rsp_err, rsp_timeout, bus_req, bus_we=0;
//    rsp_rdata, bus_addr, bus_wdata, bus_be=0. Reset mid-transaction drops req immediately.
//  - Command fields registered on accept; bus_* outputs driven from these regs, stable while req=1.
//  - FSM:
//    IDLE: cmd_ready=1. On cmd_valid -> latch cmd, clear counter, go REQ.
//    REQ: bus_req=1. bus_gnt=1 -> clear counter, go WAIT.
//      Else counter++; after GNT_TIMEOUT cycles without gnt -> req=0, rsp_timeout=1, go RSP.
//    WAIT: bus_req=0. bus_rvalid=1 -> rsp_rdata=we?0:bus_rdata, rsp_err=bus_err, go RSP.
//      Else counter++; after RVALID_TIMEOUT cycles -> rsp_timeout=1, go RSP.
//    RSP: rsp_valid=1, fields held stable. On rsp_ready -> clear rsp_*, go IDLE.
//  - cmd_ready=0 outside IDLE: exactly one outstanding transaction; no new cmd accepted in RSP.
//  - bus_rvalid outside WAIT (incl. gnt cycle) is ignored; no rdata/err capture.
//  - gnt & timeout on the same cycle: gnt wins. rvalid & timeout on the same cycle: rvalid wins.
//  - Latency, zero-wait slave (gnt comb., rvalid next cycle): accept at T; req at T+1;
//    rvalid at T+2; rsp_valid at T+3. Back-to-back throughput: one transaction / 4 cycles.
//  - Counter width $clog2(max(GNT_TIMEOUT,RVALID_TIMEOUT)+1); saturates, never wraps.
// TESTING
//  - Write we=1 addr=0x008 be=0xF wdata=0xA5A5_0001, zero-wait slave -> one req cycle,
//    bus_addr=0x008, rsp at T+3 with err=0, timeout=0, rdata=0.
//  - Read addr=0x00E with slave returning 0x1234_5678 -> bus_addr=0x00C, rsp_rdata=0x1234_5678.
//  - Slave never grants (unmapped offset) -> req high exactly 16 cycles, then rsp_timeout=1,
//    rsp_rdata=0, cmd_ready returns after rsp handshake.
//  - gnt delayed 3 cycles, rvalid delayed 5 with err=1 -> addr/wdata stable through the wait,
//    rsp_err=1, rsp_timeout=0.
//  - rsp_ready low 10 cycles -> rsp fields stable, cmd_ready=0; second cmd accepted only after handshake.
//  - rst_n low while in REQ -> bus_req=0 immediately; after release state IDLE, cmd_ready=1.

Source files
------------

// File: rtl/data_bus_initiator.sv
// Single-outstanding Ibex data-bus initiator: turns a valid/ready command stream into one bus
// transaction at a time and returns read data or status, with bounded gnt/rvalid waits.
module data_bus_initiator #(
    parameter int GNT_TIMEOUT    = 16,
    parameter int RVALID_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [6:0]  bus_wdata_intg,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CNT_MAX = (GNT_TIMEOUT > RVALID_TIMEOUT) ? GNT_TIMEOUT : RVALID_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GNT_LAST    = CNT_W'(GNT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RVALID_LAST = CNT_W'(RVALID_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_inc;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              timeout_q;

    logic              latch_cmd;
    logic              capture_rsp;
    logic              set_timeout;
    logic              clear_rsp;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    // Grant and rvalid are checked before the timeout so a last-cycle response still wins.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        latch_cmd   = 1'b0;
        capture_rsp = 1'b0;
        set_timeout = 1'b0;
        clear_rsp   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    latch_cmd  = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end else if (cnt == GNT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = RSP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    capture_rsp = 1'b1;
                    state_next  = RSP;
                end else if (cnt == RVALID_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = RSP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    clear_rsp  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Command fields are held after the transaction so the bus outputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (latch_cmd) begin
                we_q    <= cmd_we;
                addr_q  <= cmd_addr & 32'hFFFF_FFFC;
                be_q    <= cmd_be;
                wdata_q <= cmd_wdata;
            end
            if (capture_rsp) begin
                rdata_q <= we_q ? 32'h0 : bus_rdata;
                err_q   <= bus_err;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (clear_rsp) begin
                rdata_q   <= '0;
                err_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
        end
    end

    assign cmd_ready      = (state == IDLE);
    assign bus_req        = (state == REQ);
    assign rsp_valid      = (state == RSP);
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign rsp_timeout    = timeout_q;
    assign bus_we         = we_q;
    assign bus_be         = be_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign bus_wdata_intg = 7'd0;

endmodule

// File: tb/tb_data_bus_initiator.sv
// Randomized bench for data_bus_initiator: a cycle-driven slave model plus an arithmetic
// reference for response values, latency and request duration.
`timescale 1ns/1ps
module tb_data_bus_initiator;

    localparam int GNT_TO = 16;
    localparam int RV_TO  = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [6:0]  bus_wdata_intg;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    data_bus_initiator #(.GNT_TIMEOUT(GNT_TO), .RVALID_TIMEOUT(RV_TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_be        (cmd_be),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wdata_intg(bus_wdata_intg),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one command against a slave that grants after gnt_dly extra req cycles and returns
    // rvalid rv_dly cycles after the grant; the response is then held for hold cycles.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                                 input logic err, input logic [31:0] rdata, input int hold);
        int          n;
        int          req_cycles;
        int          gnt_at;
        int          exp_n;
        int          exp_req;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] held_rdata;
        bit          done;

        if (gnt_dly >= GNT_TO) begin
            exp_to = 1'b1; exp_err = 1'b0; exp_rdata = 32'h0;
            exp_req = GNT_TO; exp_n = 1 + GNT_TO;
        end else if (rv_dly > RV_TO) begin
            exp_to = 1'b1; exp_err = 1'b0; exp_rdata = 32'h0;
            exp_req = gnt_dly + 1; exp_n = 1 + gnt_dly + 1 + RV_TO;
        end else begin
            exp_to = 1'b0; exp_err = err; exp_rdata = we ? 32'h0 : rdata;
            exp_req = gnt_dly + 1; exp_n = 1 + gnt_dly + 1 + rv_dly;
        end

        @(negedge clk);
        checkOutput("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = $urandom;
        cmd_be = 4'($urandom); cmd_wdata = $urandom;

        n = 1; req_cycles = 0; gnt_at = -1; done = 1'b0;
        while (!done && n <= 100) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bus_req || gnt_at > 0) begin
                    checkOutput("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                    checkOutput("bus_wdata", bus_wdata, wdata);
                    checkOutput("bus_be", {28'b0, bus_be}, {28'b0, be});
                    checkOutput("bus_we", {31'b0, bus_we}, {31'b0, we});
                end
                if (bus_req) begin
                    req_cycles++;
                    if (req_cycles - 1 == gnt_dly) begin
                        bus_gnt    = 1'b1;
                        gnt_at     = n;
                        bus_rvalid = 1'($urandom_range(0, 1));
                    end
                end else if (gnt_at > 0 && n - gnt_at == rv_dly) begin
                    bus_rvalid = 1'b1; bus_err = err; bus_rdata = rdata;
                end
                @(posedge clk);
                @(negedge clk);
                n++;
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;

        if (!done) begin
            checkOutput("rsp_wait_bound", 32'd0, 32'd1);
            return;
        end
        checkOutput("rsp_latency", n, exp_n);
        checkOutput("req_cycles", req_cycles, exp_req);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        checkOutput("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
        checkOutput("cmd_ready_rsp", {31'b0, cmd_ready}, 32'd0);
        held_rdata = rsp_rdata;

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("hold_rdata", rsp_rdata, held_rdata);
            checkOutput("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
            checkOutput("hold_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
            checkOutput("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            checkOutput("hold_bus_req", {31'b0, bus_req}, 32'd0);
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("post_rdata", rsp_rdata, 32'd0);
        checkOutput("post_flags", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    endtask

    // Drops reset while the initiator is still requesting an unresponsive slave.
    task automatic applyResetMidReq();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0040; cmd_be = 4'hF; cmd_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pre_req", {31'b0, bus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", {31'b0, bus_req}, 32'd0);
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_after_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_after_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rst_after_rsp", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_after_addr", bus_addr, 32'd0);
    endtask

    initial begin
        int g;
        int d;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;

        @(negedge clk);
        checkOutput("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("reset_bus_we", {31'b0, bus_we}, 32'd0);
        checkOutput("reset_bus_addr", bus_addr, 32'd0);
        checkOutput("reset_bus_wdata", bus_wdata, 32'd0);
        checkOutput("reset_bus_be", {28'b0, bus_be}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_flags", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        checkOutput("wdata_intg", {25'b0, bus_wdata_intg}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 32'h0000_0008, 4'hF, 32'hA5A5_0001, 0, 1, 1'b0, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 32'h0000_000E, 4'hF, 32'h0, 0, 1, 1'b0, 32'h1234_5678, 0);
        applyStimulus(1'b0, 32'h0000_0F00, 4'h3, 32'h0, 99, 1, 1'b0, 32'h5555_AAAA, 0);
        applyStimulus(1'b1, 32'h0000_0104, 4'hC, 32'hCAFE_F00D, 3, 5, 1'b1, 32'h0, 0);
        applyStimulus(1'b0, 32'h0000_0020, 4'hF, 32'h0, 1, 2, 1'b0, 32'h0BAD_CAFE, 10);
        applyStimulus(1'b0, 32'h0000_0030, 4'hF, 32'h0, 1, 99, 1'b1, 32'h7777_7777, 0);
        applyStimulus(1'b0, 32'h0000_0034, 4'hF, 32'h0, 15, 16, 1'b0, 32'h8765_4321, 2);

        applyResetMidReq();
        applyStimulus(1'b0, 32'h0000_0044, 4'hF, 32'h0, 0, 1, 1'b0, 32'h0F0F_0F0F, 0);

        $display("[TB] random transactions");
        for (int t = 0; t < 30; t++) begin
            g = ($urandom_range(0, 7) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(0, 4);
            d = ($urandom_range(0, 7) == 0) ? 17 + $urandom_range(0, 3) : $urandom_range(1, 5);
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                          g, d, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
